// File: rtl/fetch_seq.sv
`default_nettype none
// =============================================================================
// fetch_seq : instruction-cycle sequencer driving the IP register controls.
// Rev 1.0
// =============================================================================
module fetch_seq #(
  parameter logic [15:0] RESET_VEC = 16'h0000,
  parameter logic [3:0]  OP_HALT   = 4'hF,
  parameter logic [3:0]  OP_JMP    = 4'hE,
  parameter logic [3:0]  OP_JZ     = 4'hD,
  parameter logic [3:0]  OP_JC     = 4'hC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Run,
  input  logic [15:0] MemData,
  input  logic        MemReady,
  output logic        MemRead,
  input  logic        Zero,
  input  logic        Carry,
  output logic        Next,
  output logic        JumpEn,
  output logic [15:0] JumpAddr,
  output logic [15:0] IR,
  output logic        ExecStart,
  input  logic        ExecDone,
  output logic        Halted
);

  localparam logic [2:0] S_HALT    = 3'd0;
  localparam logic [2:0] S_VECTOR  = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_DECODE  = 3'd3;
  localparam logic [2:0] S_OPFETCH = 3'd4;
  localparam logic [2:0] S_BRANCH  = 3'd5;
  localparam logic [2:0] S_EXEC    = 3'd6;

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic        boot_pending;
  logic [15:0] ir_q;
  logic [15:0] target;
  logic        taken;
  logic [3:0]  opcode;
  logic        is_branch;
  logic        cond_met;
  logic [2:0]  boundary;

  assign opcode    = ir_q[15:12];
  assign is_branch = (opcode == OP_JMP) || (opcode == OP_JZ) || (opcode == OP_JC);
  assign boundary  = Run ? S_FETCH : S_HALT;
  assign IR        = ir_q;

  // Branch condition, evaluated on the operand-fetch handshake edge
  always_comb begin
    cond_met = 1'b0;
    if (opcode == OP_JMP)     cond_met = 1'b1;
    else if (opcode == OP_JZ) cond_met = Zero;
    else if (opcode == OP_JC) cond_met = Carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_HALT;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_pending <= 1'b1;
      ir_q         <= 16'h0000;
      target       <= 16'h0000;
      taken        <= 1'b0;
    end else begin
      if (state == S_VECTOR) boot_pending <= 1'b0;
      if ((state == S_FETCH) && MemReady) ir_q <= MemData;
      if ((state == S_OPFETCH) && MemReady) begin
        target <= MemData;
        taken  <= cond_met;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_HALT:    if (Run) next_state = boot_pending ? S_VECTOR : S_FETCH;
      S_VECTOR:  next_state = S_FETCH;
      S_FETCH:   if (MemReady) next_state = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_HALT) next_state = S_HALT;
        else if (is_branch)    next_state = S_OPFETCH;
        else                   next_state = S_EXEC;
      end
      S_OPFETCH: if (MemReady) next_state = S_BRANCH;
      S_BRANCH:  next_state = boundary;
      S_EXEC:    if (ExecDone) next_state = boundary;
      default:   next_state = S_HALT;
    endcase
  end

  // Next and JumpEn are single-cycle strobes; the IP register loads on every edge
  always_comb begin
    Halted    = (state == S_HALT);
    MemRead   = (state == S_FETCH) || (state == S_OPFETCH);
    Next      = ((state == S_FETCH) && MemReady) || ((state == S_BRANCH) && !taken);
    JumpEn    = (state == S_VECTOR) || ((state == S_BRANCH) && taken);
    JumpAddr  = (state == S_VECTOR) ? RESET_VEC : target;
    ExecStart = (state == S_DECODE) && (opcode != OP_HALT) && !is_branch;
  end

endmodule
`default_nettype wire

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Instruction-cycle sequencer that drives the 16-bit instruction pointer register through its Next, JumpEn and JumpAddr controls.
- Runs fetch, decode, optional operand fetch and branch resolution, then hands non-branch instructions to the execute datapath with a start/done handshake.
- Gives the IP register, which has no reset of its own, a defined start value: after every reset it jumps to RESET_VEC.

Parameters:
- RESET_VEC, 16'h0000, IP value loaded on the first Run after reset.
- OP_HALT, 4'hF, opcode that stops the sequencer.
- OP_JMP, 4'hE, unconditional jump; two-word instruction.
- OP_JZ, 4'hD, jump if Zero; two-word instruction.
- OP_JC, 4'hC, jump if Carry; two-word instruction.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Run  in  1  enables the sequencer; sampled at instruction boundaries.
- MemData  in  16  instruction or operand word at the current IP.
- MemReady  in  1  MemData valid this cycle.
- MemRead  out  1  fetch request; memory address is the current IP.
- Zero  in  1  ALU zero flag.
- Carry  in  1  ALU carry flag.
- Next  out  1  IP increment enable (IP register Kin).
- JumpEn  out  1  IP load select.
- JumpAddr  out  16  IP load value.
- IR  out  16  latched instruction word.
- ExecStart  out  1  one-cycle start pulse to the execute datapath.
- ExecDone  in  1  execute complete.
- Halted  out  1  sequencer is in HALT.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=HALT, boot_pending=1, IR=0, Target=0, taken=0.
  - Next, JumpEn, MemRead and ExecStart are 0; Halted is 1.
  - Reset mid-operation abandons the instruction immediately; no partial IP update is issued afterwards.
- Next/JumpEn rules:
  - Both are decoded from state and inputs; never both 1.
  - Each is 1 for exactly one cycle per IP update, because the IP register captures every edge.
  - Both are 0 in every other cycle, so IP holds.
- HALT: Halted=1.
  - Run=1 with boot_pending=1 -> VECTOR.
  - Run=1 with boot_pending=0 -> FETCH.
- VECTOR (1 cycle): JumpEn=1, JumpAddr=RESET_VEC; clear boot_pending -> FETCH.
- FETCH: MemRead=1; wait for MemReady.
  - MemRead stays 1 and Next stays 0 while MemReady=0. There is no timeout.
  - On MemReady=1: IR<=MemData and Next=1 in the same cycle -> DECODE.
- DECODE (1 cycle):
  - IR[15:12]=OP_HALT -> HALT.
  - OP_JMP, OP_JZ or OP_JC -> OPFETCH.
  - Any other opcode: ExecStart=1 this cycle -> EXEC.
- OPFETCH: MemRead=1 until MemReady. On the MemReady cycle:
  - Target<=MemData.
  - taken<=1 for OP_JMP, Zero for OP_JZ, Carry for OP_JC; flags are sampled on this edge.
  - Next=0 -> BRANCH.
- BRANCH (1 cycle):
  - taken=1: JumpEn=1, JumpAddr=Target.
  - taken=0: Next=1, skipping the operand word.
  - Then go to boundary.
- EXEC: wait for ExecDone=1, then go to boundary. ExecDone is ignored in every other state.
- Boundary: Run=1 -> FETCH; Run=0 -> HALT. Run=0 never interrupts an instruction in progress.
- JumpAddr is RESET_VEC in VECTOR and Target otherwise.
- Minimum latencies:
  - Non-branch: 3 cycles (FETCH, DECODE, EXEC with ExecDone already high).
  - Branch: 4 cycles.
  - HALT: 2 cycles.
- Leaving HALT by Run without a reset resumes at the current IP (no vector).

Test Plan:
- Reset with RESET_VEC=16'h0100, then Run=1 -> Halted drops. Exactly one cycle of JumpEn=1 with JumpAddr=16'h0100, then MemRead=1; Next=0 throughout.
- Fetch 16'h1234 with MemReady immediate and ExecDone 3 cycles after ExecStart:
  - IR=16'h1234; one Next pulse; one ExecStart pulse.
  - MemRead reasserts the cycle after ExecDone.
- JZ 16'hD000 with operand 16'h0040:
  - Zero=1 -> one Next, then one JumpEn with JumpAddr=16'h0040.
  - Zero=0 -> two Next pulses total, JumpEn never asserted.
- JMP 16'hE000 with MemReady held low 2 cycles during both FETCH and OPFETCH -> MemRead held high, no Next during the waits, and JumpEn asserted exactly once.
- HALT 16'hF000 -> one Next, then Halted=1. Toggle Run 0 then 1 -> FETCH resumes with no JumpEn. Drop Run during EXEC -> HALT entered only after ExecDone.
- Assert rst_n=0 during EXEC -> all outputs clear and Halted=1 without waiting for clk. Next Run -> JumpEn to RESET_VEC again.
